cpu_instr_encoder: RTL and testbench



---
 rtl/cpu_instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_cpu_instr_encoder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_instr_encoder.sv
// Packs opcode/register fields into 16-bit IR words, queues them, and writes them to sequential memory addresses; first write one cycle after the push, one word per cycle while mem_ack stays high.
// Producer is held off only when the FIFO is full; define ENC_ILLEGAL_CHK_EN to drop reserved opcodes (in_op[4:3]==2'b11) and count them.
module cpu_instr_encoder #(
  parameter int          DEPTH = 4,
  parameter int          AW    = 8,
  parameter int unsigned BASE  = 0,
  localparam int         PW    = $clog2(DEPTH),
  localparam int         CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_op,
  input  logic [2:0]    in_da,
  input  logic [2:0]    in_aa,
  input  logic [2:0]    in_ba,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  input  logic          mem_ack,
  output logic [CW-1:0] count,
  output logic          wrapped,
  output logic          err,
  output logic [7:0]    err_cnt
);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_fifo [DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]   r_count;
  logic            r_mem_we, w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [15:0]     r_mem_wdata, w_mem_wdata_nxt;
  logic            r_wrapped, w_wrap_set;
  logic            w_pop, w_accept, w_illegal, w_push;
  logic [15:0]     w_enc;

  assign w_enc        = {2'b00, in_op, in_da, in_aa, in_ba};
  assign in_ready     = (r_count != CW'(DEPTH));
  assign w_accept     = in_valid && in_ready;
`ifdef ENC_ILLEGAL_CHK_EN
  assign w_illegal    = (in_op[4:3] == 2'b11);
`else
  assign w_illegal    = 1'b0;
`endif
  assign w_push       = w_accept && !w_illegal;
  assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign count     = r_count;
  assign wrapped   = r_wrapped;

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_pop           = 1'b0;
    w_wrap_set      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt     = S_WRITE;
          w_mem_we_nxt    = 1'b1;
          w_mem_wdata_nxt = r_fifo[r_rd_ptr];
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          w_pop          = 1'b1;
          w_mem_addr_nxt = r_mem_addr + 1'b1;
          w_wrap_set     = &r_mem_addr;
          // With one entry left the only successor is a word pushed on this same edge.
          if (r_count > CW'(1)) begin
            w_mem_wdata_nxt = r_fifo[w_rd_ptr_nxt];
          end else if (w_push) begin
            w_mem_wdata_nxt = w_enc;
          end else begin
            w_state_nxt  = S_IDLE;
            w_mem_we_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_mem_we_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_enc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= AW'(BASE);
      r_mem_wdata <= '0;
      r_wrapped   <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= AW'(BASE);
      r_wrapped   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_nxt;
      end
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      if (w_wrap_set) begin
        r_wrapped <= 1'b1;
      end
    end
  end

`ifdef ENC_ILLEGAL_CHK_EN
  logic       r_err;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_accept && w_illegal;
      if (w_accept && w_illegal && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  assign err     = r_err;
  assign err_cnt = r_err_cnt;
`else
  assign err     = 1'b0;
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_instr_encoder.sv
// Randomized and directed stimulus against a queue-based model of the encoder's write stream.
module tb_cpu_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int BASE  = 0;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ENC_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [4:0]    in_op = '0;
  logic [2:0]    in_da = '0, in_aa = '0, in_ba = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_ack = 1'b0;
  logic [CW-1:0] count;
  logic          wrapped, err;
  logic [7:0]    err_cnt;

  cpu_instr_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_da(in_da), .in_aa(in_aa), .in_ba(in_ba),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .wrapped(wrapped), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {int addr; int data;} wr_t;
  wr_t sb[$];
  int  nxt_addr = BASE, prev_size = 0, exp_err_cnt = 0;
  bit  exp_wrapped = 0, exp_err = 0, exp_we = 0;
  bit  p_push = 0, p_ack = 0, p_clr = 0, p_illegal = 0;
  int  p_data = 0;
  int  n_pass = 0, n_total = 0;

  function automatic int encode(int op, int da, int aa, int ba);
    return op * 512 + da * 64 + aa * 8 + ba;
  endfunction

  task automatic check(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      nxt_addr = BASE; exp_wrapped = 0; exp_err = 0; exp_err_cnt = 0; prev_size = 0;
      p_push = 0; p_ack = 0; p_clr = 0;
      check("rst_mem_we",    int'(mem_we),    0);
      check("rst_mem_addr",  int'(mem_addr),  BASE);
      check("rst_mem_wdata", int'(mem_wdata), 0);
      check("rst_count",     int'(count),     0);
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_wrapped",   int'(wrapped),   0);
      check("rst_err",       int'(err),       0);
      check("rst_err_cnt",   int'(err_cnt),   0);
    end else begin
      exp_err = 0;
      if (p_clr) begin
        sb.delete();
        nxt_addr = BASE; exp_wrapped = 0; exp_err_cnt = 0;
      end else begin
        if (p_ack && sb.size() > 0) begin
          if (sb[0].addr == (1 << AW) - 1) exp_wrapped = 1;
          void'(sb.pop_front());
        end
        if (p_push) begin
          if (p_illegal) begin
            exp_err = 1;
            if (exp_err_cnt < 255) exp_err_cnt++;
          end else begin
            sb.push_back('{nxt_addr, p_data});
            nxt_addr = (nxt_addr + 1) % (1 << AW);
          end
        end
      end
      // A non-empty queue is being written unless it was empty one cycle earlier.
      exp_we = (sb.size() > 0) && (prev_size > 0);
      check("count",    int'(count),    sb.size());
      check("in_ready", int'(in_ready), (sb.size() < DEPTH) ? 1 : 0);
      check("wrapped",  int'(wrapped),  int'(exp_wrapped));
      check("err",      int'(err),      int'(exp_err));
      check("err_cnt",  int'(err_cnt),  exp_err_cnt);
      check("mem_we",   int'(mem_we),   int'(exp_we));
      check("mem_addr", int'(mem_addr), (sb.size() > 0) ? sb[0].addr : nxt_addr);
      if (mem_we && sb.size() > 0) check("mem_wdata", int'(mem_wdata), sb[0].data);
      prev_size = sb.size();
      p_clr     = clr;
      p_push    = in_valid && (sb.size() < DEPTH);
      p_illegal = CHK && (in_op[4:3] == 2'b11);
      p_data    = encode(int'(in_op), int'(in_da), int'(in_aa), int'(in_ba));
      p_ack     = exp_we && mem_ack;
    end
  end

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(int op, int da, int aa, int ba);
    bit done = 0;
    in_valid = 1; in_op = 5'(op); in_da = 3'(da); in_aa = 3'(aa); in_ba = 3'(ba);
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #1;
      done = p_push;
    end
    in_valid = 0;
    if (!done) begin
      n_total++;
      $display("FAIL send_timeout: op 0x%0h never accepted, expected acceptance within 200 cycles", op);
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (sb.size() == 0 && !mem_we) done = 1;
      else cycles(1);
    end
    if (!done) begin
      n_total++;
      $display("FAIL drain_timeout: queue %0d entries, expected empty within 300 cycles", sb.size());
    end
  endtask

  initial begin
    #2 rst_n = 0;
    cycles(3);
    rst_n = 1;
    cycles(2);

    mem_ack = 1;
    send(5'b10011, 2, 5, 7);
    drain();

    mem_ack = 0;
    send(5'b00001, 1, 0, 0);
    cycles(6);
    mem_ack = 1;
    drain();

    mem_ack = 0;
    for (int i = 0; i < 4; i++) send(i + 2, i, 7 - i, i);
    in_valid = 1; in_op = 5'd9; in_da = 3'd3; in_aa = 3'd4; in_ba = 3'd5;
    cycles(3);
    mem_ack = 1;
    send(9, 3, 4, 5);
    drain();

    for (int i = 0; i < 10; i++) send(i, i % 8, (i + 3) % 8, (i * 5) % 8);
    drain();
    clr = 1;
    cycles(1);
    clr = 0;
    cycles(2);

    send(5'b11000, 0, 0, 0);
    send(5'b00001, 1, 0, 0);
    drain();

    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_op    = 5'($urandom);
      in_da    = 3'($urandom);
      in_aa    = 3'($urandom);
      in_ba    = 3'($urandom);
      mem_ack  = ($urandom_range(0, 3) != 0);
      clr      = ($urandom_range(0, 39) == 0);
      cycles(1);
    end
    in_valid = 0; clr = 0; mem_ack = 1;
    drain();

    mem_ack = 0;
    for (int i = 0; i < 3; i++) send(i + 4, i + 1, i + 2, i + 3);
    cycles(2);
    rst_n = 0;
    cycles(2);
    rst_n = 1;
    mem_ack = 1;
    cycles(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
